// File: rtl/huffman_tree.sv
// Huffman tree builder for ten 9-bit leaf frequencies.
// Runs nine merge steps, one per clock. Each step combines the two
// lightest active nodes into a new internal node (10..18).
// Records of the first eight merges are presented on Tree0..Tree7.
// The children of the final root merge are visible only on m1/m2.
module huffman_tree (
    input  logic        Clk_in,
    input  logic        n_Rst,
    input  logic        Start_tree,
    input  logic [8:0]  Num0,
    input  logic [8:0]  Num1,
    input  logic [8:0]  Num2,
    input  logic [8:0]  Num3,
    input  logic [8:0]  Num4,
    input  logic [8:0]  Num5,
    input  logic [8:0]  Num6,
    input  logic [8:0]  Num7,
    input  logic [8:0]  Num8,
    input  logic [8:0]  Num9,
    output logic [14:0] Tree0,
    output logic [14:0] Tree1,
    output logic [14:0] Tree2,
    output logic [14:0] Tree3,
    output logic [14:0] Tree4,
    output logic [14:0] Tree5,
    output logic [14:0] Tree6,
    output logic [14:0] Tree7,
    output logic [4:0]  m1,
    output logic [4:0]  m2
);

    typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;

    state_t      state;
    logic [3:0]  step;
    logic [12:0] weight [0:18];
    logic [18:0] active;
    logic [14:0] tree_reg [0:7];
    logic [8:0]  num_in [0:9];

    logic [4:0]  sel1;
    logic [4:0]  sel2;
    logic [12:0] w1;
    logic [12:0] w2;
    logic        found1;
    logic        found2;
    logic [4:0]  new_idx;
    logic [12:0] sum_w;

    assign num_in[0] = Num0;
    assign num_in[1] = Num1;
    assign num_in[2] = Num2;
    assign num_in[3] = Num3;
    assign num_in[4] = Num4;
    assign num_in[5] = Num5;
    assign num_in[6] = Num6;
    assign num_in[7] = Num7;
    assign num_in[8] = Num8;
    assign num_in[9] = Num9;

    assign Tree0 = tree_reg[0];
    assign Tree1 = tree_reg[1];
    assign Tree2 = tree_reg[2];
    assign Tree3 = tree_reg[3];
    assign Tree4 = tree_reg[4];
    assign Tree5 = tree_reg[5];
    assign Tree6 = tree_reg[6];
    assign Tree7 = tree_reg[7];

    assign new_idx = 5'(step) + 5'd10;
    assign sum_w   = w1 + w2;

    // Pick the two lightest active nodes; the ascending scan with a strict
    // less-than keeps the lower index on equal weights.
    always_comb begin
        sel1   = '0;
        w1     = '0;
        found1 = 1'b0;
        sel2   = '0;
        w2     = '0;
        found2 = 1'b0;
        for (int i = 0; i < 19; i++) begin
            if (active[i] && (!found1 || weight[i] < w1)) begin
                sel1   = 5'(i);
                w1     = weight[i];
                found1 = 1'b1;
            end
        end
        for (int i = 0; i < 19; i++) begin
            if (active[i] && (5'(i) != sel1) && (!found2 || weight[i] < w2)) begin
                sel2   = 5'(i);
                w2     = weight[i];
                found2 = 1'b1;
            end
        end
    end

    // Control FSM with node weights, active flags and registered outputs.
    always_ff @(posedge Clk_in) begin
        if (n_Rst) begin
            state  <= IDLE;
            step   <= '0;
            active <= '0;
            m1     <= '0;
            m2     <= '0;
            for (int i = 0; i < 19; i++) begin
                weight[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                tree_reg[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (Start_tree) begin
                        for (int i = 0; i < 10; i++) begin
                            weight[i] <= {4'b0000, num_in[i]};
                        end
                        for (int i = 10; i < 19; i++) begin
                            weight[i] <= '0;
                        end
                        for (int i = 0; i < 8; i++) begin
                            tree_reg[i] <= '0;
                        end
                        active <= 19'h003FF;
                        m1     <= '0;
                        m2     <= '0;
                        step   <= '0;
                        state  <= MERGE;
                    end
                end
                MERGE: begin
                    m1               <= sel1;
                    m2               <= sel2;
                    weight[new_idx]  <= sum_w;
                    active[sel1]     <= 1'b0;
                    active[sel2]     <= 1'b0;
                    active[new_idx]  <= 1'b1;
                    if (step < 4'd8) begin
                        tree_reg[step[2:0]] <= {sel1, sel2, new_idx};
                        step                <= step + 4'd1;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (!Start_tree) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_tree.sv
// Self-checking bench for huffman_tree: directed vectors plus randomized
// frequency sets compared against a behavioural merge model.
module tb_huffman_tree;

    logic        Clk_in;
    logic        n_Rst;
    logic        Start_tree;
    logic [8:0]  numDrive [10];
    logic [14:0] treeObs [8];
    logic [4:0]  m1;
    logic [4:0]  m2;

    int checkCount;
    int errorCount;

    int modelNum [10];
    int expTree  [8];
    int expM1    [9];
    int expM2    [9];

    huffman_tree dut (
        .Clk_in     (Clk_in),
        .n_Rst      (n_Rst),
        .Start_tree (Start_tree),
        .Num0       (numDrive[0]),
        .Num1       (numDrive[1]),
        .Num2       (numDrive[2]),
        .Num3       (numDrive[3]),
        .Num4       (numDrive[4]),
        .Num5       (numDrive[5]),
        .Num6       (numDrive[6]),
        .Num7       (numDrive[7]),
        .Num8       (numDrive[8]),
        .Num9       (numDrive[9]),
        .Tree0      (treeObs[0]),
        .Tree1      (treeObs[1]),
        .Tree2      (treeObs[2]),
        .Tree3      (treeObs[3]),
        .Tree4      (treeObs[4]),
        .Tree5      (treeObs[5]),
        .Tree6      (treeObs[6]),
        .Tree7      (treeObs[7]),
        .m1         (m1),
        .m2         (m2)
    );

    // Free-running clock.
    initial begin
        Clk_in = 1'b0;
        forever #5 Clk_in = ~Clk_in;
    end

    task automatic checkOutput(input string tag, input int obs, input int exp);
        checkCount++;
        if (obs != exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic stepClock();
        @(posedge Clk_in);
        #1;
    endtask

    // Reference: repeatedly pick the two lightest active nodes, lower index on ties.
    task automatic modelBuild();
        int w [19];
        bit act [19];
        int a;
        int b;
        for (int i = 0; i < 19; i++) begin
            w[i]   = (i < 10) ? modelNum[i] : 0;
            act[i] = (i < 10);
        end
        for (int s = 0; s < 9; s++) begin
            a = -1;
            for (int i = 0; i < 19; i++)
                if (act[i] && (a < 0 || w[i] < w[a])) a = i;
            b = -1;
            for (int i = 0; i < 19; i++)
                if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
            expM1[s]   = a;
            expM2[s]   = b;
            w[10+s]    = w[a] + w[b];
            act[a]     = 1'b0;
            act[b]     = 1'b0;
            act[10+s]  = 1'b1;
            if (s < 8) expTree[s] = (a << 10) | (b << 5) | (10 + s);
        end
    endtask

    task automatic checkAllZero(input string tag);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("%s_tree%0d", tag, k), int'(treeObs[k]), 0);
        checkOutput({tag, "_m1"}, int'(m1), 0);
        checkOutput({tag, "_m2"}, int'(m2), 0);
    endtask

    task automatic checkFinal(input string tag);
        for (int k = 0; k < 8; k++)
            checkOutput($sformatf("%s_tree%0d", tag, k), int'(treeObs[k]), expTree[k]);
        checkOutput({tag, "_m1"}, int'(m1), expM1[8]);
        checkOutput({tag, "_m2"}, int'(m2), expM2[8]);
    endtask

    // One full build from modelNum; optionally keep Start_tree high and
    // optionally disturb the Num inputs while merging.
    task automatic applyStimulus(input bit holdStart, input bit scramble);
        modelBuild();
        for (int i = 0; i < 10; i++) numDrive[i] = 9'(modelNum[i]);
        Start_tree = 1'b1;
        stepClock();
        checkAllZero("load");
        if (!holdStart) Start_tree = 1'b0;
        for (int s = 0; s < 9; s++) begin
            if (scramble)
                for (int i = 0; i < 10; i++) numDrive[i] = 9'($urandom_range(0, 511));
            stepClock();
            checkOutput($sformatf("step%0d_m1", s), int'(m1), expM1[s]);
            checkOutput($sformatf("step%0d_m2", s), int'(m2), expM2[s]);
            if (s < 8)
                checkOutput($sformatf("step%0d_tree", s), int'(treeObs[s]), expTree[s]);
        end
        stepClock();
        checkFinal("final");
    endtask

    task automatic randomNums(input int maxVal);
        for (int i = 0; i < 10; i++) modelNum[i] = $urandom_range(0, maxVal);
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        n_Rst      = 1'b1;
        Start_tree = 1'b0;
        for (int i = 0; i < 10; i++) numDrive[i] = '0;
        stepClock();
        stepClock();
        checkAllZero("reset");
        n_Rst = 1'b0;
        stepClock();

        $display("[TB] single heavy leaf");
        for (int i = 0; i < 10; i++) modelNum[i] = 0;
        modelNum[0] = 256;
        applyStimulus(1'b0, 1'b0);
        checkOutput("v1_tree0", int'(treeObs[0]), 'h044A);
        checkOutput("v1_tree7", int'(treeObs[7]), 'h3E11);
        checkOutput("v1_m1", int'(m1), 17);
        checkOutput("v1_m2", int'(m2), 0);
        stepClock();

        $display("[TB] mixed weights with inputs disturbed during merge");
        modelNum = '{53, 40, 26, 14, 38, 23, 7, 12, 4, 39};
        applyStimulus(1'b0, 1'b1);
        checkOutput("v2_tree0", int'(treeObs[0]), 'h20CA);
        checkOutput("v2_tree2", int'(treeObs[2]), 'h0CAC);
        checkOutput("v2_tree7", int'(treeObs[7]), 'h39F1);
        checkOutput("v2_m1", int'(m1), 16);
        checkOutput("v2_m2", int'(m2), 17);
        stepClock();

        $display("[TB] all equal weights");
        for (int i = 0; i < 10; i++) modelNum[i] = 5;
        applyStimulus(1'b0, 1'b0);
        checkOutput("v3_tree0", int'(treeObs[0]), 'h002A);
        checkOutput("v3_tree4", int'(treeObs[4]), 'h212E);
        stepClock();

        $display("[TB] reset during merge step 4");
        randomNums(511);
        for (int i = 0; i < 10; i++) numDrive[i] = 9'(modelNum[i]);
        Start_tree = 1'b1;
        stepClock();
        Start_tree = 1'b0;
        for (int s = 0; s < 4; s++) stepClock();
        n_Rst = 1'b1;
        Start_tree = 1'b1;
        stepClock();
        checkAllZero("abort");
        n_Rst = 1'b0;
        Start_tree = 1'b0;
        stepClock();
        checkAllZero("abort_idle");
        randomNums(511);
        applyStimulus(1'b0, 1'b0);
        stepClock();

        $display("[TB] start held through done");
        randomNums(63);
        applyStimulus(1'b1, 1'b0);
        for (int c = 0; c < 3; c++) stepClock();
        checkFinal("held");
        Start_tree = 1'b0;
        stepClock();
        checkFinal("idle_hold");
        randomNums(511);
        applyStimulus(1'b0, 1'b0);
        stepClock();

        $display("[TB] randomized builds");
        for (int r = 0; r < 8; r++) begin
            randomNums((r % 2 == 0) ? 7 : 511);
            applyStimulus(1'(r % 3 == 0), 1'($urandom_range(0, 1)));
            Start_tree = 1'b0;
            stepClock();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
